// File: rtl/bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bist_ctrl
//  Description : Logic BIST controller. An LFSR drives patterns into a
//                circuit under test. A MISR compacts the responses, which can
//                arrive up to three clocks late. The final signature is
//                compared against a golden value.
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_ctrl #(
    parameter int             W    = 8,
    parameter logic [W-1:0]   POLY = 8'h1D,
    parameter logic [W-1:0]   SEED = 8'h01,
    parameter int             LAT  = 0
) (
    input  logic          C,
    input  logic          RN,
    input  logic          start,
    input  logic          abort,
    input  logic [15:0]   npat,
    input  logic [W-1:0]  golden,
    output logic [W-1:0]  cut_in,
    input  logic [W-1:0]  cut_out,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [W-1:0]  sig
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [W-1:0] c_seed = (SEED == '0) ? {{(W-1){1'b0}}, 1'b1} : SEED;

    // Initial DRAIN count. DRAIN exits once the count reaches zero.
    localparam logic [1:0] c_drain_init = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_seed_st = 3'd1;
    localparam logic [2:0] c_run   = 3'd2;
    localparam logic [2:0] c_drain = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    logic [2:0]   r_state;
    logic [2:0]   w_next;
    logic [W-1:0] r_lfsr;
    logic [W-1:0] r_misr;
    logic [15:0]  r_cnt;
    logic [1:0]   r_dcnt;
    logic         r_done;
    logic         r_pass;
    logic [W-1:0] r_sig;
    logic         w_abort;
    logic         w_push;
    logic         w_tok_out;
    logic         w_start;

    // Galois shift shared by the pattern generator and the signature register.
    function automatic logic [W-1:0] f_shift(input logic [W-1:0] x);
        return {x[W-2:0], 1'b0} ^ (x[W-1] ? POLY : '0);
    endfunction

    assign w_abort = abort && (r_state != c_idle);
    assign w_start = start && (r_state == c_idle);
    assign w_push  = (r_state == c_run);

    assign cut_in = (r_state == c_run) ? r_lfsr : '0;
    assign busy   = (r_state == c_seed_st) || (r_state == c_run) || (r_state == c_drain);
    assign done   = r_done;
    assign pass   = r_pass;
    assign sig    = r_sig;

    // Each applied pattern carries a valid token. The token reaches the MISR
    // in the cycle when the matching CUT response is present on cut_out.
    generate
        if (LAT == 0) begin : g_lat_zero
            assign w_tok_out = w_push;
        end else begin : g_lat_pipe
            logic [LAT-1:0] r_vld;

            // Token delay line. It is flushed on abort so that a stale
            // response cannot reach a later run.
            always_ff @(posedge C or negedge RN) begin
                if (!RN) begin
                    r_vld <= '0;
                end else if (w_abort) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_push;
                    for (int i = 1; i < LAT; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            assign w_tok_out = r_vld[LAT-1];
        end
    endgenerate

    // State register.
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. Abort overrides every other transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:    if (start) w_next = c_seed_st;
            c_seed_st: w_next = (r_cnt != 16'd0) ? c_run : c_done;
            c_run:     if (r_cnt == 16'd1) w_next = (LAT > 0) ? c_drain : c_done;
            c_drain:   if (r_dcnt == 2'd0) w_next = c_done;
            c_done:    w_next = c_idle;
            default:   w_next = c_idle;
        endcase
        if (w_abort) begin
            w_next = c_idle;
        end
    end

    // Datapath. The run is armed on the start edge so that SEED already holds
    // the latched pattern count when it chooses between RUN and DONE.
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            r_lfsr <= c_seed;
            r_misr <= '0;
            r_cnt  <= 16'd0;
            r_dcnt <= 2'd0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_sig  <= '0;
        end else if (w_abort) begin
            r_cnt  <= 16'd0;
            r_dcnt <= 2'd0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_sig  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_lfsr <= c_seed;
                r_misr <= '0;
                r_cnt  <= npat;
                r_pass <= 1'b0;
                r_sig  <= '0;
            end else if (w_tok_out) begin
                r_misr <= f_shift(r_misr) ^ cut_out;
            end
            if (r_state == c_run) begin
                r_lfsr <= f_shift(r_lfsr);
                r_cnt  <= r_cnt - 16'd1;
                r_dcnt <= c_drain_init;
            end
            if (r_state == c_drain) begin
                r_dcnt <= r_dcnt - 2'd1;
            end
            if (r_state == c_done) begin
                r_done <= 1'b1;
                r_sig  <= r_misr;
                r_pass <= (r_misr == golden);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bist_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bist_ctrl
//  Description : Directed self-checking bench for bist_ctrl. Two instances
//                share stimulus. One has LAT=0 and an identity CUT. The other
//                has LAT=2 and an identity CUT delayed by two clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_ctrl;

    logic        C      = 1'b0;
    logic        RN     = 1'b0;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic [15:0] npat   = 16'd0;
    logic [7:0]  golden = 8'd0;

    logic [7:0]  cut_in0, cut_out0, sig0;
    logic        busy0, done0, pass0;
    logic [7:0]  cut_in2, cut_out2, sig2;
    logic        busy2, done2, pass2;
    logic [7:0]  dly1 = 8'd0;
    logic [7:0]  dly2 = 8'd0;

    int vectors     = 0;
    int miscompares = 0;
    int lat0, lat2, nd0, nd2, nb0, nb2, np0;
    logic [7:0] pats0 [0:7];

    bist_ctrl #(.W(8), .POLY(8'h1D), .SEED(8'h01), .LAT(0)) dut0 (
        .C(C), .RN(RN), .start(start), .abort(abort), .npat(npat),
        .golden(golden), .cut_in(cut_in0), .cut_out(cut_out0),
        .busy(busy0), .done(done0), .pass(pass0), .sig(sig0)
    );

    bist_ctrl #(.W(8), .POLY(8'h1D), .SEED(8'h01), .LAT(2)) dut2 (
        .C(C), .RN(RN), .start(start), .abort(abort), .npat(npat),
        .golden(golden), .cut_in(cut_in2), .cut_out(cut_out2),
        .busy(busy2), .done(done2), .pass(pass2), .sig(sig2)
    );

    assign cut_out0 = cut_in0;

    // Two-clock identity CUT for the LAT=2 instance.
    always @(posedge C) begin
        dly1 <= cut_in2;
        dly2 <= dly1;
    end
    assign cut_out2 = dly2;

    always #5 C = ~C;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge C);
        #1;
    endtask

    // Start one run, then observe 30 cycles. start_at and abort_at give the
    // cycle whose closing edge samples an extra start or abort (-1 = none).
    task automatic run(input logic [15:0] n, input logic [7:0] g,
                       input int start_at, input int abort_at);
        npat   = n;
        golden = g;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        npat   = 16'h0005;
        lat0 = -1; lat2 = -1; nd0 = 0; nd2 = 0; np0 = 0;
        nb0 = int'(busy0);
        nb2 = int'(busy2);
        for (int k = 1; k <= 30; k++) begin
            start = (k == start_at);
            abort = (k == abort_at);
            tick;
            if (done0) begin nd0++; if (lat0 < 0) lat0 = k; end
            if (done2) begin nd2++; if (lat2 < 0) lat2 = k; end
            if (busy0) nb0++;
            if (busy2) nb2++;
            if (cut_in0 != 8'd0) begin
                if (np0 < 8) pats0[np0] = cut_in0;
                np0++;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_outs0", {busy0, done0, pass0, sig0, cut_in0}, 32'd0);
        chk("reset_outs2", {busy2, done2, pass2, sig2, cut_in2}, 32'd0);
        @(posedge C);
        #1;
        RN = 1'b1;

        // Identity CUT, 3 patterns, matching golden
        run(16'd3, 8'h04, -1, -1);
        chk("pat_count0", np0, 3);
        chk("pat_seq0", {pats0[0], pats0[1], pats0[2]}, 32'h00010204);
        chk("latency0", lat0, 5);
        chk("done_pulses0", nd0, 1);
        chk("busy_cycles0", nb0, 4);
        chk("sig0_match", sig0, 32'h04);
        chk("pass0_match", pass0, 1);
        chk("latency2", lat2, 7);
        chk("busy_cycles2", nb2, 6);
        chk("sig2_match", sig2, 32'h04);
        chk("pass2_match", pass2, 1);
        chk("done_pulses2", nd2, 1);

        // Wrong golden value
        run(16'd3, 8'h05, -1, -1);
        chk("sig0_badgold", sig0, 32'h04);
        chk("pass0_badgold", pass0, 0);
        chk("done_pulses0_badgold", nd0, 1);
        chk("pass2_badgold", pass2, 0);

        // Zero patterns
        run(16'd0, 8'h00, -1, -1);
        chk("latency0_np0", lat0, 2);
        chk("latency2_np0", lat2, 2);
        chk("pat_count0_np0", np0, 0);
        chk("busy_cycles0_np0", nb0, 1);
        chk("sig0_np0", sig0, 32'h00);
        chk("pass0_np0", pass0, 1);

        // Abort during the second RUN cycle
        run(16'd3, 8'h04, -1, 3);
        chk("done_pulses0_abort", nd0, 0);
        chk("done_pulses2_abort", nd2, 0);
        chk("pat_count0_abort", np0, 2);
        chk("outs0_after_abort", {busy0, pass0, sig0}, 32'd0);
        chk("outs2_after_abort", {busy2, pass2, sig2}, 32'd0);

        // Fresh run with a start pulse while busy (must be ignored)
        run(16'd3, 8'h04, 2, -1);
        chk("latency0_busystart", lat0, 5);
        chk("done_pulses0_busystart", nd0, 1);
        chk("sig0_busystart", sig0, 32'h04);
        chk("latency2_busystart", lat2, 7);
        chk("sig2_busystart", sig2, 32'h04);

        // Reset pulse in the middle of RUN
        npat   = 16'd3;
        golden = 8'h04;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        tick;
        tick;
        chk("midrun_cutin0", cut_in0, 32'h02);
        #2;
        RN = 1'b0;
        #1;
        chk("async_reset_outs0", {busy0, done0, pass0, sig0, cut_in0}, 32'd0);
        chk("async_reset_outs2", {busy2, done2, pass2, sig2, cut_in2}, 32'd0);
        tick;
        tick;
        RN = 1'b1;
        nd0 = 0;
        nd2 = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (done0) nd0++;
            if (done2) nd2++;
        end
        chk("no_done_after_reset", nd0 + nd2, 0);

        run(16'd3, 8'h04, -1, -1);
        chk("latency0_postreset", lat0, 5);
        chk("sig0_postreset", sig0, 32'h04);
        chk("pass0_postreset", pass0, 1);
        chk("sig2_postreset", sig2, 32'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
